// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-field bundle between the pipeline decode/execute stages and the stall controller.
// Latency: none, plain wires.
// Backpressure: none; the controller answers with enables/clear on the same bundle.
interface hazard_stall_ctrl_if #(
  parameter int RW = 5,
  parameter int TW = 2
);
  logic [RW-1:0] rs_D;
  logic [RW-1:0] rt_D;
  logic [TW-1:0] tuse_rs_D;
  logic [TW-1:0] tuse_rt_D;
  logic [RW-1:0] A3_E;
  logic [TW-1:0] tnew_E;
  logic [RW-1:0] A3_M;
  logic [TW-1:0] tnew_M;
  logic          md_D;
  logic          md_start_E;
  logic          md_div_E;
  logic          enPC;
  logic          enD;
  logic          clrE;
  logic          md_busy;
  logic [31:0]   stall_cnt;

  // Pipeline side: supplies decoded hazard fields, consumes enables.
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M,
           md_D, md_start_E, md_div_E,
    input  enPC, enD, clrE, md_busy, stall_cnt
  );

  // Controller side.
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M,
           md_D, md_start_E, md_div_E,
    output enPC, enD, clrE, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall controller for the 5-stage MIPS core: Tuse/Tnew data hazards plus mult/div busy tracking.
// Latency: enables/clear are combinational (zero cycles); busy counter and stall statistics are registered.
// Backpressure: stalls hold PC and IF/ID and inject an ID/EX bubble; optional stall counter via HAZARD_STALL_STAT_EN.
module hazard_stall_ctrl #(
  parameter int RW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  logic [RW-1:0] w_rs_D;
  logic [RW-1:0] w_rt_D;
  logic [RW-1:0] w_A3_E;
  logic [RW-1:0] w_A3_M;
  logic [TW-1:0] w_tuse_rs;
  logic [TW-1:0] w_tuse_rt;
  logic [TW-1:0] w_tnew_E;
  logic [TW-1:0] w_tnew_M;
  logic          w_stall_rs;
  logic          w_stall_rt;
  logic          w_stall_md;
  logic          w_md_busy;
  logic          w_stall;
  logic [CW-1:0] r_busy_cnt;

  assign w_rs_D    = bus.rs_D;
  assign w_rt_D    = bus.rt_D;
  assign w_A3_E    = bus.A3_E;
  assign w_A3_M    = bus.A3_M;
  assign w_tuse_rs = bus.tuse_rs_D;
  assign w_tuse_rt = bus.tuse_rt_D;
  assign w_tnew_E  = bus.tnew_E;
  assign w_tnew_M  = bus.tnew_M;

  // A source register of $0 never stalls, which also keeps A3 == 0 (no write) from matching.
  assign w_stall_rs = (w_rs_D != '0) &&
                      (((w_rs_D == w_A3_E) && (w_tuse_rs < w_tnew_E)) ||
                       ((w_rs_D == w_A3_M) && (w_tuse_rs < w_tnew_M)));
  assign w_stall_rt = (w_rt_D != '0) &&
                      (((w_rt_D == w_A3_E) && (w_tuse_rt < w_tnew_E)) ||
                       ((w_rt_D == w_A3_M) && (w_tuse_rt < w_tnew_M)));

  assign w_md_busy  = (r_busy_cnt != '0);
  // The start cycle itself already blocks HI/LO users, before the counter is loaded.
  assign w_stall_md = bus.md_D && (bus.md_start_E || w_md_busy);

  // Reset forces the pipeline to run freely regardless of hazard inputs.
  assign w_stall = ~reset && (w_stall_rs || w_stall_rt || w_stall_md);

  assign bus.enPC    = ~w_stall;
  assign bus.enD     = ~w_stall;
  assign bus.clrE    = w_stall;
  assign bus.md_busy = w_md_busy;

  // MD busy counter: load on a start only when idle; a start while busy is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (bus.md_start_E && (r_busy_cnt == '0)) begin
      r_busy_cnt <= bus.md_div_E ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - CW'(1);
    end
  end

`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of stalled cycles since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised pipeline stall controller for the 5-stage MIPS core. Successor of the fixed-function stop unit, with two additions: Tuse/Tnew comparison over configurable widths, and a multi-cycle mult/div busy tracker.
- Inputs are pre-decoded hazard fields from the D, E and M stages.
- Drives PC/IF-ID enables and the ID/EX flush.
- Holds an internal latency counter so HI/LO-dependent instructions stall while the MD unit is busy.

Parameters:
- RW, 5: register address width.
- TW, 2: width of Tuse/Tnew fields.
- MULT_LAT, 5: busy cycles after a mult/multu starts.
- DIV_LAT, 10: busy cycles after a div/divu starts.
- CW, 4: busy counter width; must satisfy 2^CW-1 >= max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  RW  rs field of instr in D.
- rt_D  in  RW  rt field of instr in D.
- tuse_rs_D  in  TW  cycles until D instr needs rs; all-ones = never used.
- tuse_rt_D  in  TW  same for rt.
- A3_E  in  RW  destination reg of instr in E; 0 = no write.
- tnew_E  in  TW  cycles until E instr result is forwardable.
- A3_M  in  RW  destination reg of instr in M; 0 = no write.
- tnew_M  in  TW  same for M.
- md_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  in  1  mult/div instr is in E this cycle.
- md_div_E  in  1  qualifies md_start_E: 1 = div/divu, 0 = mult/multu.
- enPC  out  1  PC write enable.
- enD  out  1  IF/ID register enable.
- clrE  out  1  ID/EX synchronous clear (bubble insert).
- md_busy  out  1  MD unit busy (counter nonzero).
- stall_cnt  out  32  stall-cycle count (see Optional Feature).

Behaviour:
Data hazard (combinational):
- stall_rs = (rs_D != 0) && ((rs_D == A3_E && tuse_rs_D < tnew_E) || (rs_D == A3_M && tuse_rs_D < tnew_M)).
- stall_rt is the same with rt_D / tuse_rt_D.
- Compares are unsigned on TW bits.
- A3 == 0 never matches, because rs/rt == 0 is excluded.

MD counter (busy_cnt, CW bits, registered):
- reset: busy_cnt <= 0.
- else if md_start_E && busy_cnt == 0: busy_cnt <= md_div_E ? DIV_LAT : MULT_LAT.
- else if busy_cnt != 0: busy_cnt <= busy_cnt - 1.
- md_start_E while busy_cnt != 0 is ignored; the counter keeps decrementing and does not reload. Upstream stalling makes this unreachable.
- md_busy = (busy_cnt != 0), combinational from the register.

Stall outputs:
- stall_md = md_D && (md_start_E || md_busy).
- stall = stall_rs || stall_rt || stall_md.
- enPC = enD = ~stall; clrE = stall; zero-cycle latency from inputs.

Reset:
- While reset = 1: enPC = 1, enD = 1, clrE = 0 regardless of inputs.
- busy_cnt is 0 on the following cycle; md_busy reads 0 from then on.
- Reset mid-operation (busy_cnt != 0) aborts the busy period immediately at that edge.

Boundaries:
- Last busy cycle (busy_cnt == 1): md_busy = 1 and stall_md is still active.
- The next cycle has md_busy = 0 and D proceeds.
- E and M both matching the same register: either term stalls (OR).
- tuse all-ones with tnew at most all-ones never stalls.

Optional Feature:
- Macro: HAZARD_STALL_STAT_EN.
- Defined:
  - stall_cnt is a 32-bit register; reset sets it to 0.
  - Increments by 1 on each non-reset cycle where stall = 1.
  - Saturates at 0xFFFFFFFF.
- Undefined: stall_cnt is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Load-use: A3_E=8, tnew_E=2, rs_D=8, tuse_rs_D=0 -> enPC=0, enD=0, clrE=1. Next cycle A3_E=0, A3_M=8, tnew_M=1 -> still stalled. Then tnew_M=0 -> no stall.
- Zero register: rs_D=0, A3_E=0, tnew_E=2, tuse_rs_D=0 -> no stall. rt_D=9, A3_M=9, tuse_rt_D=1, tnew_M=1 -> no stall (1<1 false).
- Mult busy: md_start_E=1, md_div_E=0 for one cycle -> md_busy high for exactly 5 cycles. md_D=1 during those cycles -> stall all 5, release on the 6th. md_D=1 in the start cycle also stalls.
- Div busy, then reset: start div (DIV_LAT=10), assert reset at busy cycle 4 -> md_busy=0 the next cycle, enPC=1 during reset.
- Ignored restart: md_start_E=1 again while busy_cnt=3 -> counter continues 2,1,0 with no reload.
- With HAZARD_STALL_STAT_EN: 7 stall cycles after reset -> stall_cnt=7. Without the macro -> stall_cnt=0 throughout.
